// File: rtl/dance_pkg.sv
// Shared definitions for the dance sequencer: FSM state codes, program entry
// layout and the default eight-step choreography.
package dance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10
    } dance_state_t;

    localparam int SPEED_W   = 2;
    localparam int DIR_W     = 1;
    localparam int BEATS_W   = 4;
    localparam int ENTRY_W   = SPEED_W + DIR_W + BEATS_W;
    localparam int DEFAULT_LEN = 8;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic               direction;
        logic [BEATS_W-1:0] beats;
    } prog_entry_t;

    // Dwell on each step is beats+1 step pulses.
    localparam prog_entry_t DEFAULT_PROG [DEFAULT_LEN] = '{
        '{speed: 2'b00, direction: 1'b0, beats: 4'd3},
        '{speed: 2'b01, direction: 1'b0, beats: 4'd3},
        '{speed: 2'b10, direction: 1'b1, beats: 4'd3},
        '{speed: 2'b11, direction: 1'b1, beats: 4'd7},
        '{speed: 2'b11, direction: 1'b0, beats: 4'd7},
        '{speed: 2'b10, direction: 1'b0, beats: 4'd3},
        '{speed: 2'b01, direction: 1'b1, beats: 4'd3},
        '{speed: 2'b00, direction: 1'b1, beats: 4'd1}
    };

    // Programs longer than the table repeat it.
    function automatic prog_entry_t prog_lookup(input logic [3:0] idx);
        return DEFAULT_PROG[idx[2:0]];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton conditioning: 2-flop synchroniser, stability debouncer and a
// registered one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    // level comes out of reset as "pressed" so a button held through reset
    // must first be seen released before a new press can be reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
                press <= sync_2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dance_sequencer.sv
// Play/pause/next sequencer stepping through a ROM choreography of LED speed
// and direction, advancing on beat expiry (auto mode) or on next presses.
module dance_sequencer
    import dance_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PROG_LEN        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_play,
    input  logic                        btn_next,
    input  logic                        auto_mode,
    input  logic                        step_pulse,
    output logic [1:0]                  speed,
    output logic                        direction,
    output logic                        run_en,
    output logic [$clog2(PROG_LEN)-1:0] step_idx,
    output logic [1:0]                  state
);

    localparam int SW = $clog2(PROG_LEN);
    localparam logic [SW-1:0] LAST_STEP = SW'(PROG_LEN - 1);

    logic         play_press;
    logic         next_press;
    dance_state_t state_q;
    dance_state_t state_d;
    logic [SW-1:0] step_d;
    logic [SW-1:0] step_inc;
    logic [BEATS_W-1:0] beat_q;
    logic [BEATS_W-1:0] beat_d;
    prog_entry_t  cur;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_play),
        .press (play_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (next_press)
    );

    assign cur      = prog_lookup(4'(step_idx));
    assign step_inc = (step_idx == LAST_STEP) ? '0 : step_idx + SW'(1);
    assign state    = state_q;

    always_comb begin
        state_d = state_q;
        if (play_press) begin
            case (state_q)
                ST_IDLE:  state_d = ST_PLAY;
                ST_PLAY:  state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_PLAY;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A next press already advances by one, so a coincident beat expiry is
    // absorbed rather than adding a second step.
    always_comb begin
        step_d = step_idx;
        beat_d = beat_q;
        if (next_press) begin
            step_d = step_inc;
            beat_d = '0;
        end else if (state_q == ST_PLAY && step_pulse) begin
            if (!auto_mode) begin
                beat_d = '0;
            end else if (beat_q == cur.beats) begin
                step_d = step_inc;
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEATS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            run_en    <= 1'b0;
            step_idx  <= '0;
            beat_q    <= '0;
            speed     <= 2'b00;
            direction <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_en    <= (state_d == ST_PLAY);
            step_idx  <= step_d;
            beat_q    <= beat_d;
            speed     <= cur.speed;
            direction <= cur.direction;
        end
    end

endmodule

// File: tb/tb_dance_sequencer.sv
// Bench for dance_sequencer: directed scenarios plus random button/pulse
// traffic, scored against a behavioural model through an expected queue.
module tb_dance_sequencer;

    localparam int DEB  = 4;
    localparam int PLEN = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_play;
    logic       btn_next;
    logic       auto_mode;
    logic       step_pulse;
    logic [1:0] speed;
    logic       direction;
    logic       run_en;
    logic [2:0] step_idx;
    logic [1:0] state;

    dance_sequencer #(.DEBOUNCE_CYCLES(DEB), .PROG_LEN(PLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_play   (btn_play),
        .btn_next   (btn_next),
        .auto_mode  (auto_mode),
        .step_pulse (step_pulse),
        .speed      (speed),
        .direction  (direction),
        .run_en     (run_en),
        .step_idx   (step_idx),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Choreography as written in the requirements table.
    int ref_speed [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    int ref_dir   [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int ref_beats [8] = '{3, 3, 3, 7, 7, 3, 3, 1};

    logic [8:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 play, 2 pause.
    int m_state, m_step, m_beat, m_speed, m_dir;
    bit dly [2][2];
    bit run_val [2];
    int run_len [2];
    bit lvl [2];
    bit pend [2];
    int hold_left [2];
    bit hv [2];
    logic [8:0] mon_exp, mon_act;

    function automatic logic [8:0] pack(int st, int run, int stp, int spd, int dr);
        return {2'(st), 1'(run), 3'(stp), 2'(spd), 1'(dr)};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_step = 0; m_beat = 0; m_speed = 0; m_dir = 0;
        for (int b = 0; b < 2; b++) begin
            dly[b][0] = 0; dly[b][1] = 0;
            run_val[b] = 0; run_len[b] = 0;
            lvl[b] = 1; pend[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit raw [2];
        bit pp, np, syn;
        raw[0] = btn_play;
        raw[1] = btn_next;
        pp = pend[0];
        np = pend[1];
        // A button level is taken once it has been seen DEB times in a row,
        // two clocks after it reached the pin.
        for (int b = 0; b < 2; b++) begin
            syn = dly[b][1];
            dly[b][1] = dly[b][0];
            dly[b][0] = raw[b];
            if (syn == run_val[b]) run_len[b]++;
            else begin run_val[b] = syn; run_len[b] = 1; end
            pend[b] = 0;
            if (run_len[b] >= DEB && run_val[b] != lvl[b]) begin
                lvl[b] = run_val[b];
                pend[b] = lvl[b];
            end
        end
        m_speed = ref_speed[m_step];
        m_dir   = ref_dir[m_step];
        if (np) begin
            m_step = (m_step + 1) % PLEN;
            m_beat = 0;
        end else if (m_state == 1 && step_pulse == 1'b1) begin
            if (auto_mode == 1'b0) m_beat = 0;
            else if (m_beat == ref_beats[m_step]) begin
                m_step = (m_step + 1) % PLEN;
                m_beat = 0;
            end else m_beat++;
        end
        if (pp) m_state = (m_state == 1) ? 2 : 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        exp_q.push_back(pack(m_state, (m_state == 1) ? 1 : 0, m_step, m_speed, m_dir));
    endtask

    task automatic press(int b);
        if (b == 0) btn_play = 1'b1; else btn_next = 1'b1;
        repeat (10) tick();
        btn_play = 1'b0;
        btn_next = 1'b0;
        repeat (8) tick();
    endtask

    task automatic pulses(int n);
        repeat (n) begin
            step_pulse = 1'b1;
            tick();
            step_pulse = 1'b0;
            tick();
        end
    endtask

    task automatic check_all_reset(string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_run_en"}, run_en, 0);
        check({tag, "_step_idx"}, step_idx, 0);
        check({tag, "_speed"}, speed, 0);
        check({tag, "_direction"}, direction, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {state, run_en, step_idx, speed, direction};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs: got state=%0d run_en=%0d step=%0d speed=%0d dir=%0d expected state=%0d run_en=%0d step=%0d speed=%0d dir=%0d",
                         mon_act[8:7], mon_act[6], mon_act[5:3], mon_act[2:1], mon_act[0],
                         mon_exp[8:7], mon_exp[6], mon_exp[5:3], mon_exp[2:1], mon_exp[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; btn_play = 1'b0; btn_next = 1'b0; auto_mode = 1'b1; step_pulse = 1'b0;
        hold_left[0] = 0; hold_left[1] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();

        press(0);
        check("play_state", state, 1);
        check("play_run_en", run_en, 1);
        check("play_step", step_idx, 0);
        check("play_speed", speed, 0);

        pulses(4);
        check("auto4_step", step_idx, 1);
        check("auto4_speed", speed, 1);
        pulses(8);
        check("auto12_step", step_idx, 3);
        check("auto12_speed", speed, 3);
        check("auto12_dir", direction, 1);

        press(0);
        pulses(5);
        check("pause_state", state, 2);
        check("pause_run_en", run_en, 0);
        check("pause_step", step_idx, 3);
        press(0);
        check("resume_state", state, 1);
        pulses(8);
        check("resume_step", step_idx, 4);
        check("resume_speed", speed, 3);
        check("resume_dir", direction, 0);

        btn_next = 1'b1;
        repeat (2) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        check("glitch_step", step_idx, 4);

        auto_mode = 1'b0;
        pulses(20);
        check("manual_step", step_idx, 4);
        auto_mode = 1'b1;

        repeat (3) press(1);
        check("next3_step", step_idx, 7);
        pulses(1);
        btn_next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_pulse = (i == 6);
            tick();
        end
        step_pulse = 1'b0;
        btn_next = 1'b0;
        repeat (8) tick();
        check("coincident_wrap_step", step_idx, 0);

        repeat (5) press(1);
        check("pre_reset_step", step_idx, 5);
        check("pre_reset_state", state, 1);

        btn_play = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_reset("midplay_reset");
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        check("held_through_reset_state", state, 0);
        btn_play = 1'b0;
        repeat (10) tick();
        press(0);
        check("replay_state", state, 1);

        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold_left[b] == 0) begin
                    hv[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 14);
                end
                hold_left[b]--;
            end
            btn_play = hv[0];
            btn_next = hv[1];
            step_pulse = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            tick();
        end
        btn_play = 1'b0;
        btn_next = 1'b0;
        step_pulse = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dance_sequencer.md
DANCE_SEQUENCER -- requirements
Module: dance_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, sets button stable time in clk cycles (10 ms at 100 MHz).
REQ-002 Parameter PROG_LEN, default 8, sets the number of program steps (power of two, 2..16).
REQ-003 clk  input  1  100 MHz system clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_play  input  1  raw play/pause pushbutton, asynchronous to clk.
REQ-006 btn_next  input  1  raw next-step pushbutton, asynchronous to clk.
REQ-007 auto_mode  input  1  switch; 1 = program advances on beat expiry, 0 = manual advance only.
REQ-008 step_pulse  input  1  one-cycle tick from the LED rate generator, one per LED shift.
REQ-009 speed  output  2  speed code to the rate generator.
REQ-010 direction  output  1  rotate direction to the LED shifter.
REQ-011 run_en  output  1  high while LEDs may shift; gates step_pulse into the shifter.
REQ-012 step_idx  output  $clog2(PROG_LEN)  current program step.
REQ-013 state  output  2  FSM state code (IDLE=00, PLAY=01, PAUSE=10).

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a level only after DEBOUNCE_CYCLES consecutive equal samples, then a rising-edge detector giving a one-cycle press pulse.
REQ-015 Program ROM entry SHALL be {speed[1:0], direction, beats[3:0]}; dwell = beats+1 step_pulses (1..16).
REQ-016 FSM: IDLE -play-> PLAY; PLAY -play-> PAUSE; PAUSE -play-> PLAY; no other transitions except reset.
REQ-017 run_en SHALL be 1 only in PLAY.
REQ-018 In PLAY with auto_mode=1, beat_cnt SHALL increment on each step_pulse; on step_pulse with beat_cnt==beats, step_idx advances and beat_cnt clears.
REQ-019 step_pulse SHALL be ignored in IDLE and PAUSE; beat_cnt and step_idx hold.
REQ-020 With auto_mode=0, beat expiry SHALL NOT advance step_idx; beat_cnt holds at 0.
REQ-021 A next press SHALL advance step_idx by one and clear beat_cnt in any state.
REQ-022 step_idx SHALL wrap PROG_LEN-1 -> 0.
REQ-023 Next press and beat expiry in the same cycle SHALL advance step_idx by exactly one.
REQ-024 Play and next press in the same cycle SHALL both take effect.
REQ-025 speed and direction SHALL be registered from ROM[step_idx], valid one cycle after step_idx changes; all outputs registered.
REQ-026 Latency from press pulse to state/step_idx change SHALL be 1 clk.

Reset
REQ-027 rst SHALL immediately force state=IDLE, run_en=0, step_idx=0, beat_cnt=0, speed=2'b00, direction=0, clear synchronisers/debouncers; mid-PLAY reset aborts the program.
REQ-028 After rst deasserts, a button held through reset SHALL NOT produce a press until released and pressed again.

Structure
REQ-029 Package dance_pkg SHALL hold FSM state encodings, ROM entry field widths and the 8-entry default program table.
REQ-030 Default program: {00,0,3},{01,0,3},{10,1,3},{11,1,7},{11,0,7},{10,0,3},{01,1,3},{00,1,1}.
REQ-031 One sub-module btn_debounce (sync + debounce + edge detect) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, press play 10 cycles -> state=PLAY, run_en=1, step_idx=0, speed=00, direction=0.
REQ-033 PLAY, auto_mode=1, 4 step_pulses -> step_idx=1, speed=01 one cycle later; 8 more pulses -> step_idx=3, speed=11, direction=1.
REQ-034 Play pressed in PLAY, then 5 step_pulses -> state=PAUSE, run_en=0, step_idx and beat_cnt unchanged; play again resumes count.
REQ-035 step_idx=7, next press coincident with 2nd (final) step_pulse -> step_idx=0 (single advance, wrap).
REQ-036 btn_next glitch of 2 cycles -> no advance; auto_mode=0 with 20 step_pulses -> step_idx unchanged.
REQ-037 rst asserted mid-PLAY at step_idx=5 -> all outputs at reset values same cycle; held button gives no press after release of rst.
